// File: rtl/oam_dma_sink.sv
// oam_dma_sink: OAM-side receiver for the OAM DMA transfer.
// Each DMA byte is registered with its low address byte and written to the
// 16-bit OAM array one clock later through a byte-lane write strobe. CPU
// accesses are arbitrated against DMA and PPU activity. The block also
// tracks how far the transfer has progressed and flags address errors.
//
// Ports:
//   clk, nreset                 clock, asynchronous active-low reset
//   dma_run, dma_strobe         transfer active level, per-byte valid pulse
//   dma_a_lo, dma_d             OAM byte index and data from the DMA engine
//   cpu_sel, cpu_a, cpu_wd      CPU decode hit, byte index, write data
//   cpu_wr, cpu_rd              CPU write pulse, read level
//   ppu_busy                    PPU currently owns OAM
//   oam_rd                      OAM read word (lo lane = even byte)
//   oam_a, oam_wd               OAM word address, write byte
//   oam_we_lo, oam_we_hi        even / odd byte-lane write strobes
//   cpu_rd_d, cpu_rd_oe         CPU read data and bus drive enable
//   dma_done, dma_err           completion pulse, sticky sequence error
module oam_dma_sink #(
  parameter int unsigned OAM_BYTES = 160,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              dma_run,
  input  logic              dma_strobe,
  input  logic [ADDR_W-1:0] dma_a_lo,
  input  logic [7:0]        dma_d,
  input  logic              cpu_sel,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [7:0]        cpu_wd,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic              ppu_busy,
  input  logic [15:0]       oam_rd,
  output logic [ADDR_W-2:0] oam_a,
  output logic [7:0]        oam_wd,
  output logic              oam_we_lo,
  output logic              oam_we_hi,
  output logic [7:0]        cpu_rd_d,
  output logic              cpu_rd_oe,
  output logic              dma_done,
  output logic              dma_err
);

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(OAM_BYTES);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(OAM_BYTES - 1);

  logic              run_q,  run_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] exp_q,  exp_d;
  logic              err_q,  err_d;
  logic              done_q, done_d;

  logic              rise;
  logic [ADDR_W-1:0] exp_base;
  logic              err_base;
  logic              cpu_allow;
  logic              cpu_in_range;
  logic              cpu_wr_ok;

  // State registers; reset drops any pending byte without writing it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      run_q  <= 1'b0;
      pend_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      exp_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      pend_q <= pend_d;
      addr_q <= addr_d;
      data_q <= data_d;
      exp_q  <= exp_d;
      err_q  <= err_d;
      done_q <= done_d;
    end
  end

  // DMA capture stage, sequence check and completion detect.
  always_comb begin
    rise     = dma_run & ~run_q;
    // A new transfer restarts the sequence check in its very first cycle.
    exp_base = rise ? '0 : exp_q;
    err_base = rise ? 1'b0 : err_q;

    run_d  = dma_run;
    pend_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    exp_d  = exp_base;
    err_d  = err_base;
    done_d = pend_q && (addr_q == LAST);

    if (dma_strobe && dma_run) begin
      if (dma_a_lo >= LIMIT) begin
        err_d = 1'b1;
      end else begin
        pend_d = 1'b1;
        addr_d = dma_a_lo;
        data_d = dma_d;
        if (dma_a_lo != exp_base) begin
          err_d = 1'b1;
        end
        // Resync on mismatch; after the last byte this lands on LIMIT.
        exp_d = dma_a_lo + ADDR_W'(1);
      end
    end
  end

  // OAM port mux: a committing DMA byte always beats the CPU.
  always_comb begin
    cpu_allow    = ~dma_run & ~ppu_busy & ~pend_q;
    cpu_in_range = cpu_a < LIMIT;
    cpu_wr_ok    = nreset & cpu_sel & cpu_wr & cpu_allow & cpu_in_range;

    oam_a     = '0;
    oam_wd    = 8'h00;
    oam_we_lo = 1'b0;
    oam_we_hi = 1'b0;

    if (pend_q) begin
      oam_a     = addr_q[ADDR_W-1:1];
      oam_wd    = data_q;
      oam_we_lo = ~addr_q[0];
      oam_we_hi = addr_q[0];
    end else if (nreset) begin
      // Idle: keep the address stable for the PPU-side mux outside.
      oam_a = cpu_a[ADDR_W-1:1];
      if (cpu_wr_ok) begin
        oam_wd    = cpu_wd;
        oam_we_lo = ~cpu_a[0];
        oam_we_hi = cpu_a[0];
      end
    end
  end

  // CPU read path: open-bus 0xFF whenever OAM is not available.
  always_comb begin
    cpu_rd_oe = nreset & cpu_sel & cpu_rd;
    cpu_rd_d  = 8'h00;
    if (cpu_rd_oe) begin
      if (cpu_allow && cpu_in_range) begin
        cpu_rd_d = cpu_a[0] ? oam_rd[15:8] : oam_rd[7:0];
      end else begin
        cpu_rd_d = 8'hFF;
      end
    end
  end

  assign dma_done = done_q;
  assign dma_err  = err_q;

endmodule
